// File: rtl/picoblaze_lcd_writer.sv
// PicoBlaze output-port peripheral that writes a byte or a nibble to a
// HD44780-style character LCD in 4-bit mode. It generates the timing for
// setup, the E pulse, the inter-nibble gap and the execution wait, and it
// reports busy/overrun through a status byte.
module picoblaze_lcd_writer #(
  parameter logic [7:0] DATA_PORT_ID   = 8'h01,
  parameter logic [7:0] CMD_PORT_ID    = 8'h02,
  parameter logic [7:0] NIB_PORT_ID    = 8'h03,
  parameter logic [7:0] STATUS_PORT_ID = 8'h04,
  parameter int         T_AS           = 2,
  parameter int         T_PW           = 12,
  parameter int         T_NIB          = 50,
  parameter int         T_EXEC         = 2000,
  parameter int         T_CLR          = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] status,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  // The counter must hold the longest wait (clear/home); never narrower than 17 bits.
  localparam int CNT_W = ($clog2(T_CLR + 1) > 17) ? $clog2(T_CLR + 1) : 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_HI,
    S_E_HI,
    S_GAP,
    S_SET_LO,
    S_E_LO,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             nib_q;
  logic             busy_q;
  logic             overrun_q, overrun_d;
  logic             lcd_e_q;
  logic [3:0]       lcd_d_q, lcd_d_d;
  logic             port_hit;
  logic             accept;
  logic             long_wait;
  logic [CNT_W-1:0] wait_load;

  // A state lasting n cycles is entered with n-1, so it exits on the cycle the count is 0.
  function automatic logic [CNT_W-1:0] load(input int n);
    return CNT_W'(n - 1);
  endfunction

  assign port_hit  = write_strobe &&
                     (port_id == DATA_PORT_ID || port_id == CMD_PORT_ID || port_id == NIB_PORT_ID);
  assign accept    = port_hit && (state_q == S_IDLE);
  // Clear display / return home need the long execution wait; everything else the short one.
  assign long_wait = !rs_q && !nib_q && (byte_q inside {8'h01, 8'h02, 8'h03});
  assign wait_load = long_wait ? load(T_CLR) : load(T_EXEC);

  // Next-state, counter reload, overrun and nibble-select decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcd_d_d   = lcd_d_q;
    overrun_d = overrun_q;

    if (read_strobe && port_id == STATUS_PORT_ID) overrun_d = 1'b0;
    if (port_hit && busy_q)                       overrun_d = 1'b1;

    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_SET_HI;
        cnt_d   = load(T_AS);
        lcd_d_d = out_port[7:4];
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (state_q)
        S_SET_HI: begin state_d = S_E_HI; cnt_d = load(T_PW); end
        S_E_HI: begin
          if (nib_q) begin state_d = S_WAIT; cnt_d = wait_load;   end
          else       begin state_d = S_GAP;  cnt_d = load(T_NIB); end
        end
        S_GAP: begin
          state_d = S_SET_LO;
          cnt_d   = load(T_AS);
          lcd_d_d = byte_q[3:0];
        end
        S_SET_LO: begin state_d = S_E_LO; cnt_d = load(T_PW); end
        S_E_LO:   begin state_d = S_WAIT; cnt_d = wait_load;  end
        S_WAIT:   begin state_d = S_IDLE; cnt_d = '0;         end
        default:  begin state_d = S_IDLE; cnt_d = '0;         end
      endcase
    end
  end

  // State, counter, latched transfer and registered LCD pins.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
      nib_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      lcd_e_q   <= 1'b0;
      lcd_d_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != S_IDLE);
      overrun_q <= overrun_d;
      lcd_e_q   <= (state_d == S_E_HI) || (state_d == S_E_LO);
      lcd_d_q   <= lcd_d_d;
      if (accept) begin
        byte_q <= out_port;
        rs_q   <= (port_id == DATA_PORT_ID);
        nib_q  <= (port_id == NIB_PORT_ID);
      end
    end
  end

  assign status = {6'b0, overrun_q, busy_q};
  assign lcd_e  = lcd_e_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_d  = lcd_d_q;

endmodule

// File: tb/tb_picoblaze_lcd_writer.sv
// Directed bench for picoblaze_lcd_writer: walks data, command, nibble,
// overrun, back-to-back and mid-transfer reset scenarios, measuring the LCD
// pin timeline cycle by cycle against hand-computed expectations.
module tb_picoblaze_lcd_writer;

  localparam logic [7:0] DATA_P = 8'h01;
  localparam logic [7:0] CMD_P  = 8'h02;
  localparam logic [7:0] NIB_P  = 8'h03;
  localparam logic [7:0] STAT_P = 8'h04;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] status;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_d;

  int n_checks = 0;
  int n_pass   = 0;

  picoblaze_lcd_writer dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .status       (status),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_d        (lcd_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called on a negedge; holds the write for exactly one rising edge.
  task automatic do_write(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic do_read(input logic [7:0] p);
    port_id     = p;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  // Entered on the first busy negedge after acceptance; returns on the first
  // negedge with busy=0. Optionally injects a DATA write of 8'h42 at inj_at.
  task automatic observe(input string tag, input int exp_pulses,
                         input logic [3:0] exp_n0, input logic [3:0] exp_n1,
                         input logic exp_rs, input int exp_wait, input int inj_at,
                         output logic [7:0] st_inj);
    int         cyc = 0;
    int         pulses = 0;
    int         last_fall = -1;
    int         e_start [2];
    int         e_len [2];
    logic [3:0] nib [2];
    logic [3:0] cur_nib = 4'h0;
    logic [3:0] d_p1 = 4'h0;
    logic [3:0] d_p2 = 4'h0;
    logic       prev_e = 1'b0;
    logic       bad_d = 1'b0;
    logic       bad_rs = 1'b0;
    st_inj = 8'h00;
    for (int i = 0; i < 2; i++) begin e_start[i] = -1; e_len[i] = -1; nib[i] = 4'h0; end
    while (status[0] && cyc < 100000) begin
      if (lcd_rs !== exp_rs) bad_rs = 1'b1;
      if (lcd_e && !prev_e) begin
        if (d_p1 !== lcd_d || d_p2 !== lcd_d) bad_d = 1'b1;
        cur_nib = lcd_d;
        if (pulses < 2) begin e_start[pulses] = cyc; nib[pulses] = lcd_d; end
        pulses++;
      end
      if (lcd_e && lcd_d !== cur_nib) bad_d = 1'b1;
      if (!lcd_e && prev_e) begin
        if (lcd_d !== cur_nib) bad_d = 1'b1;
        if (pulses >= 1 && pulses <= 2) e_len[pulses-1] = cyc - e_start[pulses-1];
        last_fall = cyc;
      end
      if (cyc == inj_at + 2) st_inj = status;
      prev_e = lcd_e;
      d_p2   = d_p1;
      d_p1   = lcd_d;
      if (cyc == inj_at) begin
        port_id = DATA_P; out_port = 8'h42; write_strobe = 1'b1;
      end else if (cyc == inj_at + 1) begin
        write_strobe = 1'b0; port_id = 8'h00;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done"},    32'(status[0]), 32'd0);
    check({tag, ".pulses"},  pulses, exp_pulses);
    check({tag, ".setup0"},  e_start[0], 2);
    check({tag, ".nib0"},    nib[0], exp_n0);
    check({tag, ".pw0"},     e_len[0], 12);
    if (exp_pulses == 2) begin
      check({tag, ".start1"}, e_start[1], 66);
      check({tag, ".nib1"},   nib[1], exp_n1);
      check({tag, ".pw1"},    e_len[1], 12);
    end
    check({tag, ".wait"},    cyc - last_fall, exp_wait);
    check({tag, ".d_stable"}, bad_d, 0);
    check({tag, ".rs"},       bad_rs, 0);
    check({tag, ".rw"},       lcd_rw, 0);
  endtask

  initial begin
    logic [7:0] st;
    int         e_cnt;
    reset        = 1'b1;
    port_id      = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    out_port     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.e",      lcd_e, 0);
    check("rst.rs",     lcd_rs, 0);
    check("rst.rw",     lcd_rw, 0);
    check("rst.d",      lcd_d, 0);
    check("rst.status", status, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Non-matching port is ignored entirely.
    do_write(8'h07, 8'h41);
    check("ignore.status", status, 8'h00);
    @(negedge clk);

    // Data 'A' with an overrunning write in the gap.
    do_write(DATA_P, 8'h41);
    observe("data41", 2, 4'h4, 4'h1, 1'b1, 2000, 20, st);
    check("ovr.status_busy", st, 8'h03);
    check("ovr.status_idle", status, 8'h02);
    do_read(STAT_P);
    check("ovr.cleared", status, 8'h00);

    // Short command, then clear display issued on the first idle cycle.
    do_write(CMD_P, 8'h0C);
    observe("cmd0c", 2, 4'h0, 4'hC, 1'b0, 2000, -10, st);
    do_write(CMD_P, 8'h01);
    check("b2b.status", status, 8'h01);
    observe("cmd01", 2, 4'h0, 4'h1, 1'b0, 82000, -10, st);

    // Single init nibble.
    do_write(NIB_P, 8'h30);
    observe("nib30", 1, 4'h3, 4'h0, 1'b0, 2000, -10, st);

    // Reset during the low-nibble E pulse (cycles 66..77), overrun set first.
    do_write(DATA_P, 8'h55);
    for (int i = 0; i < 70; i++) begin
      if (i == 20) begin
        port_id = CMD_P; out_port = 8'h66; write_strobe = 1'b1;
      end else if (i == 21) begin
        write_strobe = 1'b0; port_id = 8'h00;
      end
      @(negedge clk);
    end
    check("mid.in_e_lo", lcd_e, 1);
    check("mid.status",  status, 8'h03);
    reset = 1'b1;
    @(negedge clk);
    check("mid.rst_e",      lcd_e, 0);
    check("mid.rst_status", status, 8'h00);
    check("mid.rst_d",      lcd_d, 0);
    reset = 1'b0;
    e_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (lcd_e) e_cnt++;
      @(negedge clk);
    end
    check("mid.no_e",   e_cnt, 0);
    check("mid.idle",   status, 8'h00);
    do_write(NIB_P, 8'h20);
    observe("post_rst", 1, 4'h2, 4'h0, 1'b0, 2000, -10, st);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/picoblaze_lcd_writer.md
PICOBLAZE_LCD_WRITER -- requirements
Module: picoblaze_lcd_writer

Interface
REQ-001 Parameter DATA_PORT_ID, default 8'h01: port_id that writes a character byte (RS=1).
REQ-002 Parameter CMD_PORT_ID, default 8'h02: port_id that writes an instruction byte (RS=0).
REQ-003 Parameter NIB_PORT_ID, default 8'h03: port_id that writes a single upper nibble (RS=0); used for the init sequence.
REQ-004 Parameter STATUS_PORT_ID, default 8'h04: port_id whose read clears the overrun flag.
REQ-005 Parameters T_AS=2, T_PW=12, T_NIB=50, T_EXEC=2000, T_CLR=82000: cycle counts at 50 MHz for setup, E pulse width, inter-nibble gap, normal execution wait and clear/home wait.
REQ-006 clk  in  1  system clock (CLK_50M at top level).
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 port_id  in  8  PicoBlaze port address.
REQ-009 write_strobe  in  1  PicoBlaze write qualifier.
REQ-010 read_strobe  in  1  PicoBlaze read qualifier.
REQ-011 out_port  in  8  PicoBlaze write data.
REQ-012 status  out  8  {6'b0, overrun, busy}, registered, muxed onto in_port by the top level.
REQ-013 lcd_e  out  1  LCD enable strobe.
REQ-014 lcd_rs  out  1  LCD register select.
REQ-015 lcd_rw  out  1  LCD read/write; constant 0.
REQ-016 lcd_d  out  4  LCD DB7..DB4; top level drives DB3..DB0 to Z.

Function
REQ-017 A write is accepted when write_strobe=1, port_id matches DATA/CMD/NIB_PORT_ID and busy=0; byte and RS are latched on that edge.
REQ-018 busy SHALL be 1 from the cycle after acceptance until the FSM re-enters IDLE; busy=0 exactly when state is IDLE.
REQ-019 A matching write while busy=1 is dropped and sets overrun=1 (sticky); the transfer in flight is unaffected.
REQ-020 overrun clears on the edge with read_strobe=1 and port_id=STATUS_PORT_ID; a simultaneous set wins.
REQ-021 States: IDLE, SET_HI, E_HI, GAP, SET_LO, E_LO, WAIT.
REQ-022 Byte write: IDLE->SET_HI (lcd_d=byte[7:4], E=0, T_AS cycles)->E_HI (E=1, T_PW)->GAP (E=0, T_NIB)->SET_LO (lcd_d=byte[3:0], T_AS)->E_LO (E=1, T_PW)->WAIT->IDLE.
REQ-023 Nibble write: IDLE->SET_HI->E_HI->WAIT->IDLE using out_port[7:4]; exactly one E pulse.
REQ-024 WAIT lasts T_CLR cycles for CMD bytes 8'h01, 8'h02, 8'h03; T_EXEC cycles otherwise (incl. nibble and data writes).
REQ-025 lcd_d and lcd_rs SHALL be stable from start of SET_x through end of the following E state and the first cycle after E falls.
REQ-026 lcd_e is registered, glitch-free, high only in E_HI/E_LO.
REQ-027 Single down-counter, 17 bits minimum, loaded on each state entry; state advances when count reaches 0; no counter wrap.
REQ-028 A write in the first cycle busy=0 after WAIT is accepted (back-to-back with zero dead cycles beyond WAIT).
REQ-029 Non-matching port_id writes are ignored and do not set overrun.

Reset
REQ-030 On reset: state IDLE, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=4'h0, busy=0, overrun=0, counter=0.
REQ-031 Reset mid-transfer SHALL force lcd_e=0 on the next edge and abandon the transfer; no further E pulses.

Verification
REQ-032 Write 8'h41 to DATA_PORT_ID -> RS=1; E pulse 12 cycles with lcd_d=4'h4, gap 50, E pulse 12 with lcd_d=4'h1, busy held 2000 cycles in WAIT, then busy=0.
REQ-033 Write 8'h01 to CMD_PORT_ID -> RS=0, two E pulses (4'h0, 4'h1), WAIT 82000 cycles; write 8'h0C -> WAIT 2000.
REQ-034 Write 8'h30 to NIB_PORT_ID -> exactly one E pulse with lcd_d=4'h3, RS=0, then WAIT 2000.
REQ-035 Write 8'h42 while busy -> overrun=1, status=8'h03, output sequence of first byte unchanged; read STATUS_PORT_ID -> overrun=0.
REQ-036 Assert reset during E_LO -> lcd_e=0 next cycle, status=8'h00, subsequent write executes normally.
REQ-037 Write on busy-falling cycle -> accepted, busy=1 next cycle, overrun stays 0.
